// File: rtl/cba_pkg.sv
// Shared constants and helpers for the cba carry-bypass adder.
package cba_pkg;

   localparam int CBA_WIDTH  = 32;
   localparam int CBA_BLOCK  = 4;
   localparam int NUM_BLOCKS = CBA_WIDTH / CBA_BLOCK;

   // Number of ripple/bypass blocks for a given width/block size.
   function automatic int cba_num_blocks(input int width, input int block);
      return width / block;
   endfunction

endpackage

// File: rtl/cba_block.sv
// One BLOCK-bit ripple-carry slice with a carry-bypass mux on its carry-out.
// c_msb is the carry into the slice MSB; the top uses it for signed overflow.
module cba_block
   import cba_pkg::*;
#(
   parameter int BLOCK = CBA_BLOCK
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [BLOCK-1:0] p;
   logic [BLOCK-1:0] g;
   logic             ripple_co;

   // Bitwise ripple: sum bits, carry into the MSB, and the rippled carry-out.
   always_comb begin
      logic cy;
      p         = a ^ b;
      g         = a & b;
      s         = '0;
      c_msb     = 1'b0;
      cy        = cin;
      for (int i = 0; i < BLOCK; i++) begin
         s[i]  = p[i] ^ cy;
         c_msb = cy;
         cy    = g[i] | (p[i] & cy);
      end
      ripple_co = cy;
   end

   // When every bit propagates, the block carry-out is just its carry-in,
   // so the long path skips the ripple chain entirely.
   assign cout = (&p) ? cin : ripple_co;

endmodule

// File: rtl/cba.sv
// Registered carry-bypass (carry-skip) adder with carry-out and signed overflow.
// Optional build macro: CBA_INPUT_REG_EN adds input registers (latency 2).
module cba
   import cba_pkg::*;
#(
   parameter int WIDTH = CBA_WIDTH,
   parameter int BLOCK = CBA_BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Cin,
   output logic [WIDTH-1:0] sum,
   output logic             Cout,
   output logic             of
);

   localparam int NB = cba_num_blocks(WIDTH, BLOCK);

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_c;

`ifdef CBA_INPUT_REG_EN
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;

   // Operand capture stage; cleared by reset so no stale operand survives it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         cin_q <= 1'b0;
      end else begin
         a_q   <= a;
         b_q   <= b;
         cin_q <= Cin;
      end
   end

   assign op_a = a_q;
   assign op_b = b_q;
   assign op_c = cin_q;
`else
   assign op_a = a;
   assign op_b = b;
   assign op_c = Cin;
`endif

   logic [NB:0]      c;
   logic [NB-1:0]    c_msb;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             of_d;

   assign c[0] = op_c;

   // Block chain: each block's bypassed carry-out feeds the next block.
   for (genvar i = 0; i < NB; i++) begin : g_blk
      cba_block #(
         .BLOCK (BLOCK)
      ) u_blk (
         .a     (op_a[i*BLOCK +: BLOCK]),
         .b     (op_b[i*BLOCK +: BLOCK]),
         .cin   (c[i]),
         .s     (sum_d[i*BLOCK +: BLOCK]),
         .cout  (c[i+1]),
         .c_msb (c_msb[i])
      );
   end

   // Signed overflow: carry into the MSB differs from carry out of it.
   assign cout_d = c[NB];
   assign of_d   = c_msb[NB-1] ^ c[NB];

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             of_q;

   // Result registers; reset clears them without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         of_q   <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         of_q   <= of_d;
      end
   end

   assign sum  = sum_q;
   assign Cout = cout_q;
   assign of   = of_q;

endmodule

// File: tb/tb_cba.sv
// Bench for cba: arithmetic reference model checked every cycle, plus
// hand-computed directed vectors, an asynchronous reset check and random runs.
module tb_cba;

   localparam int W = 32;
`ifdef CBA_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         Cin   = 1'b0;
   logic [W-1:0] sum;
   logic         Cout;
   logic         of;

   always #5 clk = ~clk;

   cba #(.WIDTH(W), .BLOCK(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .Cin   (Cin),
      .sum   (sum),
      .Cout  (Cout),
      .of    (of)
   );

   int vecs = 0;
   int errs = 0;
   bit chk  = 1'b0;

   // Operands accepted by the design, oldest at index LAT-1. Reset empties
   // the pipe, which is equivalent to zero operands (0+0+0 gives all-zero outputs).
   logic [W-1:0] ha [LAT] = '{default: '0};
   logic [W-1:0] hb [LAT] = '{default: '0};
   logic         hc [LAT] = '{default: 1'b0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            ha[i] <= '0;
            hb[i] <= '0;
            hc[i] <= 1'b0;
         end
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            ha[i] <= ha[i-1];
            hb[i] <= hb[i-1];
            hc[i] <= hc[i-1];
         end
         ha[0] <= a;
         hb[0] <= b;
         hc[0] <= Cin;
      end
   end

   // Reference: plain wide addition, overflow from the sign rule.
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci);
      logic [W:0] t;
      logic       ov;
      t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return {ov, t[W], t[W-1:0]};
   endfunction

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk) begin
         logic [W+1:0] e;
         e = ref_add(ha[LAT-1], hb[LAT-1], hc[LAT-1]);
         vecs++;
         if ({of, Cout, sum} !== e) begin
            errs++;
            $display("FAIL model t=%0t got sum=%h cout=%b of=%b want sum=%h cout=%b of=%b",
                     $time, sum, Cout, of, e[W-1:0], e[W], e[W+1]);
         end
      end
   end

   task automatic check_lit(input string name, input logic [W-1:0] es, input logic ec,
                            input logic eo);
      vecs++;
      if (sum !== es || Cout !== ec || of !== eo) begin
         errs++;
         $display("FAIL %s got sum=%h cout=%b of=%b want sum=%h cout=%b of=%b",
                  name, sum, Cout, of, es, ec, eo);
      end
   endtask

   // Drive a vector, wait the pipeline latency, then compare to literals.
   task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input logic [W-1:0] es, input logic ec,
                           input logic eo);
      @(negedge clk);
      #1;
      a   = x;
      b   = y;
      Cin = ci;
      repeat (LAT) @(posedge clk);
      #2;
      check_lit(name, es, ec, eo);
   endtask

   task automatic run_random(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         a   = $urandom;
         Cin = 1'($urandom_range(0, 1));
         case (k % 4)
            0:       b = ~a;                           // every block bypasses
            1:       b = ~a ^ (32'h1 << $urandom_range(0, 31));
            default: b = $urandom;
         endcase
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk = 1'b1;                         // outputs under reset must read 0
      #1;
      check_lit("reset_state", '0, 1'b0, 1'b0);
      rst_n = 1'b1;

      directed("pos_ovf",     32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
      directed("neg_ovf",     32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
      directed("cin_mix",     32'h12345678, 32'h12345670, 1'b1, 32'h2468ACE9, 1'b0, 1'b0);
      directed("msb_only",    32'h12345678, 32'h80000000, 1'b0, 32'h92345678, 1'b0, 1'b0);
      directed("all_ones",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
      directed("partial",     32'hFFFFF999, 32'h00000111, 1'b0, 32'hFFFFFAAA, 1'b0, 1'b0);
      directed("full_bypass", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
      directed("small",       32'h00000420, 32'h00000420, 1'b1, 32'h00000841, 1'b0, 1'b0);
      directed("pre_reset",   32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

      // Reset away from any clock edge: outputs must clear immediately.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_lit("async_reset", '0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      a     = 32'h0000FFFF;
      b     = 32'h00000001;
      Cin   = 1'b0;
      rst_n = 1'b1;
      repeat (LAT) @(posedge clk);
      #2;
      check_lit("post_reset", 32'h00010000, 1'b0, 1'b0);

      run_random(10000);

      // Let the last random vectors drain through the pipeline.
      repeat (LAT + 1) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
